// File: rtl/fadd_far_arb_if.sv
// rtl/fadd_far_arb_if.sv - requester/result handshake bundle for the shared far-path adder arbiter
interface fadd_far_arb_if #(
    parameter int FRAC_WIDTH = 36,
    parameter int EXP_WIDTH  = 8
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [FRAC_WIDTH-1:0] req0_esmall;
    logic [FRAC_WIDTH-1:0] req0_elarge;
    logic [EXP_WIDTH-1:0]  req0_exp;
    logic [EXP_WIDTH:0]    req0_diff;
    logic                  req0_sub;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [FRAC_WIDTH-1:0] req1_esmall;
    logic [FRAC_WIDTH-1:0] req1_elarge;
    logic [EXP_WIDTH-1:0]  req1_exp;
    logic [EXP_WIDTH:0]    req1_diff;
    logic                  req1_sub;

    logic                  res_valid;
    logic                  res_ready;
    logic [FRAC_WIDTH-1:0] res_frac;
    logic [EXP_WIDTH-1:0]  res_exp;
    logic                  res_tag;
    logic                  busy;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_esmall, req0_elarge, req0_exp, req0_diff, req0_sub,
        output req0_ready,
        input  req1_valid, req1_esmall, req1_elarge, req1_exp, req1_diff, req1_sub,
        output req1_ready,
        output res_valid, res_frac, res_exp, res_tag, busy,
        input  res_ready
    );

    // Requester / result consumer side
    modport master (
        output req0_valid, req0_esmall, req0_elarge, req0_exp, req0_diff, req0_sub,
        input  req0_ready,
        output req1_valid, req1_esmall, req1_elarge, req1_exp, req1_diff, req1_sub,
        input  req1_ready,
        input  res_valid, res_frac, res_exp, res_tag, busy,
        output res_ready
    );
endinterface

// File: rtl/fadd_far_arb.sv
// rtl/fadd_far_arb.sv - two-port round-robin arbiter around one far-path adder; optional FADD_FAR_ARB_CNT_EN result counters
module fadd_far_arb #(
    parameter int FRAC_WIDTH = 36,
    parameter int EXP_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                rst,
    fadd_far_arb_if.slave       bus
`ifdef FADD_FAR_ARB_CNT_EN
    ,
    output logic [15:0]         cnt0,
    output logic [15:0]         cnt1
`endif
);
    localparam int SW = FRAC_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_last;       // 1: port1 granted last
    logic [FRAC_WIDTH-1:0] r_esmall;
    logic [FRAC_WIDTH-1:0] r_elarge;
    logic [EXP_WIDTH-1:0]  r_exp;
    logic [EXP_WIDTH:0]    r_diff;
    logic                  r_sub;
    logic                  r_tag;
    logic [FRAC_WIDTH-1:0] r_res_frac;
    logic [EXP_WIDTH-1:0]  r_res_exp;
    logic                  r_res_tag;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_ready0;
    logic                  w_ready1;
    logic                  w_accept;
    logic                  w_res_hs;
    logic [FRAC_WIDTH-1:0] w_shifted;
    logic [SW-1:0]         w_sum;
    logic [FRAC_WIDTH-1:0] w_frac;
    logic [EXP_WIDTH-1:0]  w_exp;

    // Round-robin: a lone valid wins, on contention the port not granted last wins
    assign w_gnt0 = bus.req0_valid & (~bus.req1_valid | r_last);
    assign w_gnt1 = bus.req1_valid & (~bus.req0_valid | ~r_last);

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.res_valid  = (r_state == ST_DONE);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.res_frac   = r_res_frac;
    assign bus.res_exp    = r_res_exp;
    assign bus.res_tag    = r_res_tag;
    assign w_res_hs       = (r_state == ST_DONE) & bus.res_ready;

    // State register; reset abandons any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and handshake outputs; readys only ever asserted in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready0 = w_gnt0;
                w_ready1 = w_gnt1;
                if (w_gnt0 | w_gnt1) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_DONE;
            ST_DONE: if (bus.res_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Far-path alignment: shifts of the full width or more flush the small operand
    always_comb begin
        w_shifted = '0;
        if (r_diff < (EXP_WIDTH+1)'(FRAC_WIDTH))
            w_shifted = r_esmall >> r_diff;
    end

    assign w_sum = r_sub ? ({1'b0, r_elarge} - {1'b0, w_shifted})
                         : ({1'b0, r_elarge} + {1'b0, w_shifted});

    // One-position normalisation; exponent wraps silently
    always_comb begin
        w_frac = w_sum[FRAC_WIDTH-1:0];
        w_exp  = r_exp;
        if (w_sum[SW-1]) begin
            w_frac = w_sum[SW-1:1];
            w_exp  = r_exp + EXP_WIDTH'(1);
        end else if (w_sum[SW-2] == 1'b0) begin
            w_frac = {w_sum[FRAC_WIDTH-2:0], 1'b0};
            w_exp  = r_exp - EXP_WIDTH'(1);
        end
    end

    // Operand capture on accept, result capture in the single EXEC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= 1'b1;
            r_esmall   <= '0;
            r_elarge   <= '0;
            r_exp      <= '0;
            r_diff     <= '0;
            r_sub      <= 1'b0;
            r_tag      <= 1'b0;
            r_res_frac <= '0;
            r_res_exp  <= '0;
            r_res_tag  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last   <= w_gnt1;
                r_tag    <= w_gnt1;
                r_esmall <= w_gnt1 ? bus.req1_esmall : bus.req0_esmall;
                r_elarge <= w_gnt1 ? bus.req1_elarge : bus.req0_elarge;
                r_exp    <= w_gnt1 ? bus.req1_exp    : bus.req0_exp;
                r_diff   <= w_gnt1 ? bus.req1_diff   : bus.req0_diff;
                r_sub    <= w_gnt1 ? bus.req1_sub    : bus.req0_sub;
            end
            if (r_state == ST_EXEC) begin
                r_res_frac <= w_frac;
                r_res_exp  <= w_exp;
                r_res_tag  <= r_tag;
            end
        end
    end

`ifdef FADD_FAR_ARB_CNT_EN
    // Per-port completed-result counters, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (w_res_hs) begin
            if (!r_res_tag && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
            if ( r_res_tag && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_res_hs;
`endif
endmodule

// File: tb/tb_fadd_far_arb.sv
// tb/tb_fadd_far_arb.sv - directed vector bench for fadd_far_arb
module tb_fadd_far_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fadd_far_arb_if #(.FRAC_WIDTH(36), .EXP_WIDTH(8)) bus ();

`ifdef FADD_FAR_ARB_CNT_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    fadd_far_arb #(.FRAC_WIDTH(36), .EXP_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .cnt0(cnt0), .cnt1(cnt1));
`else
    fadd_far_arb #(.FRAC_WIDTH(36), .EXP_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
`endif

    typedef struct {
        bit        port;
        bit [35:0] elarge;
        bit [35:0] esmall;
        bit [7:0]  exp;
        bit [8:0]  diff;
        bit        sub;
        bit [35:0] x_frac;
        bit [7:0]  x_exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_port(input bit p, input bit v, input vec_t t);
        if (p == 1'b0) begin
            bus.req0_valid = v; bus.req0_elarge = t.elarge; bus.req0_esmall = t.esmall;
            bus.req0_exp = t.exp; bus.req0_diff = t.diff; bus.req0_sub = t.sub;
        end else begin
            bus.req1_valid = v; bus.req1_elarge = t.elarge; bus.req1_esmall = t.esmall;
            bus.req1_exp = t.exp; bus.req1_diff = t.diff; bus.req1_sub = t.sub;
        end
    endtask

    task automatic result_handshake();
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        vec_t z;
        z = '{0, 36'h0, 36'h0, 8'h0, 9'h0, 0, 36'h0, 8'h0};
        vecs[0] = '{0, 36'h800000000, 36'h800000000, 8'h10, 9'd0,  0, 36'h800000000, 8'h11};
        vecs[1] = '{1, 36'h800000000, 36'h800000000, 8'h10, 9'd1,  1, 36'h800000000, 8'h0F};
        vecs[2] = '{0, 36'hC00000000, 36'hFFFFFFFFF, 8'h20, 9'd40, 0, 36'hC00000000, 8'h20};
        vecs[3] = '{0, 36'h900000000, 36'h800000000, 8'h30, 9'd4,  0, 36'h980000000, 8'h30};
        vecs[4] = '{1, 36'h800000000, 36'h800000000, 8'hFF, 9'd0,  0, 36'h800000000, 8'h00};
        vecs[5] = '{0, 36'h800000000, 36'h800000000, 8'h00, 9'd1,  1, 36'h800000000, 8'hFF};
        vecs[6] = '{1, 36'h800000000, 36'hFFFFFFFFF, 8'h40, 9'd35, 0, 36'h800000001, 8'h40};
        vecs[7] = '{0, 36'h800000000, 36'hFFFFFFFFF, 8'h40, 9'd36, 0, 36'h800000000, 8'h40};

        drive_port(0, 0, z);
        drive_port(1, 0, z);
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("rst_busy", bus.busy, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_frac", bus.res_frac, 0);
        chk("rst_res_exp", bus.res_exp, 0);
        chk("rst_res_tag", bus.res_tag, 0);
`ifdef FADD_FAR_ARB_CNT_EN
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
`endif

        // contention right after reset: port0 first, then alternation
        drive_port(0, 1, vecs[0]);
        drive_port(1, 1, vecs[0]);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("cont%0d_ready0", k), bus.req0_ready, (k % 2 == 0));
            chk($sformatf("cont%0d_ready1", k), bus.req1_ready, (k % 2 == 1));
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("cont%0d_exec_readys", k), {bus.req0_ready, bus.req1_ready}, 0);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("cont%0d_valid", k), bus.res_valid, 1);
            chk($sformatf("cont%0d_tag", k), bus.res_tag, k % 2);
            result_handshake();
        end
        drive_port(0, 0, z);
        drive_port(1, 0, z);
`ifdef FADD_FAR_ARB_CNT_EN
        chk("cnt0_after_cont", cnt0, 2);
        chk("cnt1_after_cont", cnt1, 2);
`endif

        // vector table: accept at T, result visible at T+2
        foreach (vecs[i]) begin
            @(negedge clk);
            drive_port(vecs[i].port, 1, vecs[i]);
            #1;
            chk($sformatf("v%0d_ready", i),
                vecs[i].port ? bus.req1_ready : bus.req0_ready, 1);
            @(posedge clk);
            @(negedge clk);
            drive_port(vecs[i].port, 0, z);
            chk($sformatf("v%0d_t1_valid", i), bus.res_valid, 0);
            chk($sformatf("v%0d_t1_busy", i), bus.busy, 1);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), bus.res_valid, 1);
            chk($sformatf("v%0d_frac", i), bus.res_frac, vecs[i].x_frac);
            chk($sformatf("v%0d_exp", i), bus.res_exp, vecs[i].x_exp);
            chk($sformatf("v%0d_tag", i), bus.res_tag, vecs[i].port);
            result_handshake();
            chk($sformatf("v%0d_idle", i), bus.busy, 0);
        end

        // backpressure: 5 cycles held in DONE
        drive_port(1, 1, vecs[6]);
        @(posedge clk);
        @(negedge clk);
        drive_port(1, 0, z);
        drive_port(0, 1, vecs[3]);
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k), bus.res_valid, 1);
            chk($sformatf("bp%0d_frac", k), bus.res_frac, 36'h800000001);
            chk($sformatf("bp%0d_tag", k), bus.res_tag, 1);
            chk($sformatf("bp%0d_readys", k), {bus.req0_ready, bus.req1_ready}, 0);
            chk($sformatf("bp%0d_busy", k), bus.busy, 1);
            @(posedge clk);
        end
        @(negedge clk);
        drive_port(0, 0, z);
        result_handshake();
        chk("bp_done_idle", bus.busy, 0);
        chk("bp_done_valid", bus.res_valid, 0);

        // reset during EXEC discards the operation
        drive_port(0, 1, vecs[0]);
        @(posedge clk);
        @(negedge clk);
        drive_port(0, 0, z);
        chk("rx_in_exec", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rx_busy", bus.busy, 0);
        chk("rx_valid", bus.res_valid, 0);
        chk("rx_frac", bus.res_frac, 0);
`ifdef FADD_FAR_ARB_CNT_EN
        chk("rx_cnt0", cnt0, 0);
        chk("rx_cnt1", cnt1, 0);
`endif
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rx_quiet%0d", k), bus.res_valid, 0);
        end

        // reset wins over a simultaneous request handshake
        drive_port(1, 1, vecs[1]);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive_port(1, 0, z);
        chk("rprio_busy", bus.busy, 0);

        // pointer back to 1 after reset: port0 wins contention again
        drive_port(0, 1, vecs[0]);
        drive_port(1, 1, vecs[1]);
        #1;
        chk("rprio_ready0", bus.req0_ready, 1);
        chk("rprio_ready1", bus.req1_ready, 0);
        drive_port(0, 0, z);
        drive_port(1, 0, z);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
